// File: rtl/sprite_line_render.sv
// Sprite line renderer: fetches one sprite row per line from an external
// ROM during horizontal blanking, then overlays it on the next active line.
// The pixel outputs and the delayed syncs are all registered one cycle
// behind the timing generator signals that produced them.
module sprite_line_render #(
  parameter int H_RES       = 1024,
  parameter int V_RES       = 768,
  parameter int SPR_W       = 8,
  parameter int SPR_H       = 8,
  parameter int SCALE_SHIFT = 0,
  parameter int COLR_BITS   = 4,
  parameter int TRANSP      = 0,
  parameter int ADDR_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [11:0]          sx,
  input  logic [11:0]          sy,
  input  logic                 de,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [11:0]          spr_x,
  input  logic [11:0]          spr_y,
  input  logic                 spr_en,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [COLR_BITS-1:0] rom_data,
  output logic [COLR_BITS-1:0] pix,
  output logic                 pix_en,
  output logic                 pix_de,
  output logic                 pix_hs,
  output logic                 pix_vs
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state;
  logic [CW-1:0]       idx;
  logic                cap_valid;
  logic [CW-1:0]       cap_idx;
  logic                line_valid;
  logic                de_q;
  logic [11:0]         x_q;
  logic [11:0]         y_q;
  logic                en_q;
  logic [COLR_BITS-1:0] linebuf [SPR_W];

  // Line-end detection and hit test for the line about to be drawn.
  // The first line of a frame is tested against the live position because
  // the latched copy is only being loaded on that same cycle.
  logic                line_end;
  logic                last_line;
  logic [11:0]         next_line;
  logic [11:0]         hit_y;
  logic                hit_en;
  logic [12:0]         dy;
  logic [12:0]         row_full;
  logic                hit;
  logic [ADDR_W-1:0]   base_addr;

  assign line_end  = de_q & ~de;
  assign last_line = (sy == 12'(V_RES - 1));
  assign next_line = last_line ? 12'd0 : sy + 12'd1;
  assign hit_y     = last_line ? spr_y : y_q;
  assign hit_en    = last_line ? spr_en : en_q;
  assign dy        = {1'b0, next_line} - {1'b0, hit_y};
  assign row_full  = dy >> SCALE_SHIFT;
  assign hit       = hit_en && (next_line >= hit_y) && (row_full < 13'(SPR_H));
  assign base_addr = ADDR_W'({row_full[RW-1:0], {CW{1'b0}}});

  // Column lookup for the pixel currently presented by the timing generator.
  logic [12:0]          dx;
  logic [12:0]          col_full;
  logic [CW-1:0]        col;
  logic                 in_spr;
  logic [COLR_BITS-1:0] cur;
  logic                 opaque;

  assign dx       = {1'b0, sx} - {1'b0, x_q};
  assign col_full = dx >> SCALE_SHIFT;
  assign col      = col_full[CW-1:0];
  assign in_spr   = line_valid && de && (sx >= x_q) && (col_full < 13'(SPR_W))
                    && (sx < 12'(H_RES));
  assign cur      = linebuf[col];
  assign opaque   = in_spr && (cur != COLR_BITS'(TRANSP));

  // Latch the sprite position once per frame so mid-frame moves take effect next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      en_q <= 1'b0;
    end else if (line_end && last_line) begin
      x_q  <= spr_x;
      y_q  <= spr_y;
      en_q <= spr_en;
    end
  end

  // Row fetch sequencer; a line end always restarts it for the new line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      rom_addr   <= '0;
      line_valid <= 1'b0;
      cap_valid  <= 1'b0;
      cap_idx    <= '0;
    end else begin
      cap_valid <= 1'b0;
      if (line_end) begin
        line_valid <= 1'b0;
        idx        <= '0;
        if (hit) begin
          state    <= FETCH;
          rom_addr <= base_addr;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          FETCH: begin
            cap_valid <= 1'b1;
            cap_idx   <= idx;
            rom_addr  <= rom_addr + ADDR_W'(1);
            idx       <= idx + CW'(1);
            if (idx == CW'(SPR_W - 1)) state <= DRAIN;
          end
          DRAIN: begin
            line_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Capture ROM data one cycle after its address was issued.
  always_ff @(posedge clk) begin
    if (cap_valid) linebuf[cap_idx] <= rom_data;
  end

  // Register pixel output and delay the timing signals by the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix    <= '0;
      pix_en <= 1'b0;
      pix_de <= 1'b0;
      pix_hs <= 1'b0;
      pix_vs <= 1'b0;
      de_q   <= 1'b0;
    end else begin
      pix    <= opaque ? cur : '0;
      pix_en <= opaque;
      pix_de <= de;
      pix_hs <= hsync;
      pix_vs <= vsync;
      de_q   <= de;
    end
  end

endmodule

// File: tb/tb_sprite_line_render.sv
// Testbench for sprite_line_render: shortened lines with a directed table of
// expected pixels, plus sequences for fetch addressing, scaling, clipping,
// mid-frame moves and reset during a fetch. A second instance uses scale 2.
module tb_sprite_line_render;

  localparam int BL = 14;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] sx, sy;
  logic        de, hsync, vsync;
  logic [11:0] spr_x, spr_y;
  logic        spr_en;

  logic [5:0]  rom_addr0, rom_addr1;
  logic [3:0]  rom_data0, rom_data1;
  logic [3:0]  pix0, pix1;
  logic        pix_en0, pix_en1, pix_de0, pix_de1, pix_hs0, pix_hs1, pix_vs0, pix_vs1;

  sprite_line_render dut (
    .clk(clk), .reset_n(reset_n), .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .pix(pix0), .pix_en(pix_en0), .pix_de(pix_de0), .pix_hs(pix_hs0), .pix_vs(pix_vs0)
  );

  sprite_line_render #(.SCALE_SHIFT(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .pix(pix1), .pix_en(pix_en1), .pix_de(pix_de1), .pix_hs(pix_hs1), .pix_vs(pix_vs1)
  );

  // Pixel clock.
  always #5 clk = ~clk;

  // Identity sprite ROMs with one cycle read latency.
  always @(posedge clk) begin
    rom_data0 <= rom_addr0[3:0];
    rom_data1 <= rom_addr1[3:0];
  end

  typedef struct {
    int tag;
    int dut;
    int sx;
    int pix;
    int en;
  } vec_t;

  vec_t       tbl[$];
  int         checks = 0;
  int         errors = 0;
  int         dly_err = 0;
  logic [3:0] cap_pix [2][1024];
  logic       cap_en  [2][1024];
  int         blank_addr [BL];
  logic [11:0] p_sx = '0;
  logic       p_de = 1'b0, p_hs = 1'b0, p_vs = 1'b0;

  function automatic void addVec(int tag, int d, int x, int p, int e);
    vec_t v;
    v.tag = tag; v.dut = d; v.sx = x; v.pix = p; v.en = e;
    tbl.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one cycle; outputs seen at the following negedge belong to the
  // previous cycle's inputs, so a combinational path would show up here.
  task automatic applyStimulus(input logic [11:0] nsx, input logic [11:0] nsy,
                               input logic nde, input logic nhs, input logic nvs);
    @(posedge clk);
    #1;
    sx = nsx; sy = nsy; de = nde; hsync = nhs; vsync = nvs;
    @(negedge clk);
    if (pix_de0 !== p_de || pix_hs0 !== p_hs || pix_vs0 !== p_vs) dly_err++;
    if (pix_de1 !== p_de || pix_hs1 !== p_hs || pix_vs1 !== p_vs) dly_err++;
    if (p_de) begin
      cap_pix[0][p_sx[9:0]] = pix0;
      cap_en[0][p_sx[9:0]]  = pix_en0;
      cap_pix[1][p_sx[9:0]] = pix1;
      cap_en[1][p_sx[9:0]]  = pix_en1;
    end
    p_sx = nsx; p_de = nde; p_hs = nhs; p_vs = nvs;
  endtask

  task automatic pulseReset();
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_rom_addr0", int'(rom_addr0), 0);
    checkOutput("rst_rom_addr1", int'(rom_addr1), 0);
    checkOutput("rst_pix_hs0", int'(pix_hs0), 0);
    checkOutput("rst_pix_hs1", int'(pix_hs1), 0);
    checkOutput("rst_pix_vs0", int'(pix_vs0), 0);
    checkOutput("rst_pix_en0", int'(pix_en0), 0);
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic runLine(input int y, input int x0, input int n, input int rst_at);
    logic v;
    v = (y == 767);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < n; k++) begin
        cap_pix[d][x0+k] = '0;
        cap_en[d][x0+k]  = 1'b0;
      end
    for (int k = 0; k < n; k++) applyStimulus(12'(x0 + k), 12'(y), 1'b1, 1'b0, v);
    for (int k = 0; k < BL; k++) begin
      applyStimulus(12'(1030 + k), 12'(y), 1'b0, (k >= 2 && k <= 5), v);
      blank_addr[k] = int'(rom_addr0);
      if (k == rst_at) pulseReset();
    end
  endtask

  function automatic int countEn(int d, int x0, int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(cap_en[d][x0+k]);
    return c;
  endfunction

  task automatic checkLine(input int tag);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].tag == tag) begin
        checkOutput($sformatf("t%0d_d%0d_sx%0d_en", tag, tbl[i].dut, tbl[i].sx),
                    int'(cap_en[tbl[i].dut][tbl[i].sx]), tbl[i].en);
        checkOutput($sformatf("t%0d_d%0d_sx%0d_pix", tag, tbl[i].dut, tbl[i].sx),
                    int'(cap_pix[tbl[i].dut][tbl[i].sx]), tbl[i].pix);
      end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Expected pixels: {tag, dut, sx, pix, en}
    addVec(1, 0, 100, 0, 0);  addVec(1, 0, 101, 0, 0);
    addVec(2, 0, 99, 0, 0);   addVec(2, 0, 100, 0, 0);  addVec(2, 0, 101, 1, 1);
    addVec(2, 0, 107, 7, 1);  addVec(2, 0, 108, 0, 0);
    addVec(3, 0, 99, 0, 0);   addVec(3, 0, 100, 8, 1);  addVec(3, 0, 103, 11, 1);
    addVec(3, 0, 107, 15, 1); addVec(3, 0, 108, 0, 0);
    addVec(4, 0, 100, 8, 1);  addVec(4, 0, 107, 15, 1); addVec(4, 0, 200, 0, 0);
    addVec(5, 0, 100, 0, 0);  addVec(5, 0, 199, 0, 0);  addVec(5, 0, 200, 8, 1);
    addVec(5, 0, 207, 15, 1); addVec(5, 0, 208, 0, 0);
    addVec(6, 0, 200, 0, 0);  addVec(6, 0, 201, 0, 0);
    addVec(7, 0, 1019, 0, 0); addVec(7, 0, 1020, 0, 0); addVec(7, 0, 1021, 1, 1);
    addVec(7, 0, 1023, 3, 1);
    addVec(8, 0, 1020, 8, 1); addVec(8, 0, 1023, 11, 1);
    addVec(9, 0, 1020, 8, 1); addVec(9, 0, 1023, 11, 1);
    addVec(10, 1, 0, 0, 0);   addVec(10, 1, 1, 0, 0);   addVec(10, 1, 2, 1, 1);
    addVec(10, 1, 3, 1, 1);   addVec(10, 1, 14, 7, 1);  addVec(10, 1, 15, 7, 1);
    addVec(10, 1, 16, 0, 0);  addVec(10, 0, 1, 1, 1);   addVec(10, 0, 8, 0, 0);
    addVec(11, 1, 2, 1, 1);   addVec(11, 1, 15, 7, 1);  addVec(11, 1, 16, 0, 0);
    addVec(11, 0, 0, 8, 1);
    addVec(12, 1, 0, 8, 1);   addVec(12, 1, 1, 8, 1);   addVec(12, 1, 2, 9, 1);
    addVec(13, 0, 100, 0, 0); addVec(13, 0, 101, 0, 0);
    addVec(14, 0, 100, 8, 1); addVec(14, 0, 107, 15, 1);

    $display("[TB] sprite_line_render test start");
    reset_n = 1'b0;
    sx = 12'd5; sy = 12'd7; de = 1'b1; hsync = 1'b1; vsync = 1'b1;
    spr_x = 12'd100; spr_y = 12'd50; spr_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rom_addr", int'(rom_addr0), 0);
    checkOutput("reset_pix", int'(pix0), 0);
    checkOutput("reset_pix_en", int'(pix_en0), 0);
    checkOutput("reset_pix_de", int'(pix_de0), 0);
    checkOutput("reset_pix_hs", int'(pix_hs0), 0);
    checkOutput("reset_pix_vs", int'(pix_vs0), 0);
    sx = '0; sy = '0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;

    // First frame after reset draws nothing.
    runLine(49, 96, 120, -1);
    runLine(50, 96, 120, -1);
    checkLine(1);
    checkOutput("t1_count", countEn(0, 96, 120), 0);

    // Identity sprite at (100,50), with transparency on row 0.
    runLine(767, 96, 120, -1);
    runLine(49, 96, 120, -1);
    runLine(50, 96, 120, -1);
    checkLine(2);
    checkOutput("t2_count", countEn(0, 96, 120), 7);
    for (int j = 0; j < 8; j++)
      checkOutput($sformatf("rom_addr_%0d", j), blank_addr[j+1], 8 + j);
    runLine(51, 96, 120, -1);
    checkLine(3);
    checkOutput("t3_count", countEn(0, 96, 120), 8);

    // Mid-frame move is ignored until the next frame.
    spr_x = 12'd200;
    runLine(300, 96, 120, -1);
    runLine(50, 96, 120, -1);
    runLine(51, 96, 120, -1);
    checkLine(4);
    checkOutput("t4_count", countEn(0, 96, 120), 8);
    runLine(767, 96, 120, -1);
    runLine(50, 96, 120, -1);
    runLine(51, 96, 120, -1);
    checkLine(5);
    checkOutput("t5_count", countEn(0, 96, 120), 8);

    // Sprite disabled.
    spr_en = 1'b0;
    runLine(767, 96, 120, -1);
    runLine(50, 96, 120, -1);
    runLine(51, 96, 120, -1);
    checkLine(6);
    checkOutput("t6_count", countEn(0, 96, 120), 0);

    // Clipping at the bottom-right corner.
    spr_x = 12'd1020; spr_y = 12'd764; spr_en = 1'b1;
    runLine(767, 1012, 12, -1);
    runLine(763, 1012, 12, -1);
    runLine(764, 1012, 12, -1);
    checkLine(7);
    checkOutput("t7_count", countEn(0, 1012, 12), 3);
    runLine(765, 1012, 12, -1);
    checkLine(8);
    checkOutput("t8_count", countEn(0, 1012, 12), 4);
    runLine(766, 1012, 12, -1);
    runLine(767, 1012, 12, -1);
    checkLine(9);
    checkOutput("t9_count", countEn(0, 1012, 12), 4);

    // Scaled sprite at the origin (second instance).
    spr_x = 12'd0; spr_y = 12'd0;
    runLine(767, 0, 24, -1);
    runLine(0, 0, 24, -1);
    checkLine(10);
    checkOutput("t10_count_s", countEn(1, 0, 24), 14);
    runLine(1, 0, 24, -1);
    checkLine(11);
    runLine(2, 0, 24, -1);
    checkLine(12);
    checkOutput("t12_count_s", countEn(1, 0, 24), 16);

    // Reset in the middle of a fetch, then recovery.
    spr_x = 12'd100; spr_y = 12'd50;
    runLine(767, 96, 120, -1);
    runLine(49, 96, 120, -1);
    runLine(50, 96, 120, 3);
    runLine(51, 96, 120, -1);
    checkLine(13);
    checkOutput("t13_count", countEn(0, 96, 120), 0);
    runLine(767, 96, 120, -1);
    runLine(50, 96, 120, -1);
    runLine(51, 96, 120, -1);
    checkLine(14);
    checkOutput("t14_count", countEn(0, 96, 120), 8);

    checkOutput("sync_delay", dly_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
